// File: rtl/pipeline_ctrl.sv
// Hazard/redirect controller for a 5-stage pipeline: stage enables, bubbles,
// PC select, a one-bit redirect-wait FSM and saturating stall/flush counters.
module pipeline_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ex_br_sel,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             im_ready,
  input  logic             dm_req,
  input  logic             dm_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic [1:0]       pc_sel,
  output logic             state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [0:0] RUN        = 1'b0;
  localparam logic [0:0] REDIR_WAIT = 1'b1;

  logic [0:0] cur_state, nxt_state;
  logic [1:0] pend_sel, nxt_pend;
  logic       dstall, redir, luse;

  assign dstall = dm_req & ~dm_ready;
  assign redir  = ex_br_sel != 2'b00;
  assign luse   = ex_mem_read & (ex_rd != 5'd0) &
                  ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));

  assign state = cur_state;

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    id_ex_we     = 1'b1;
    ex_mem_we    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    pc_sel       = 2'b00;
    nxt_state    = cur_state;
    nxt_pend     = pend_sel;
    if (rst) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
      nxt_state    = RUN;
      nxt_pend     = 2'b00;
    end else if (dstall) begin
      // Memory stall freezes everything, including any redirect in EX.
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (cur_state == REDIR_WAIT) begin
      // A redirect seen now is ignored: EX holds a bubble while waiting.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      pc_we       = im_ready;
      pc_sel      = im_ready ? pend_sel : 2'b00;
      if (im_ready) nxt_state = RUN;
    end else if (redir) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      if (im_ready) begin
        pc_sel = ex_br_sel;
      end else begin
        pc_we     = 1'b0;
        nxt_state = REDIR_WAIT;
        nxt_pend  = ex_br_sel;
      end
    end else if (luse) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (!im_ready) begin
      pc_we       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= RUN;
      pend_sel  <= 2'b00;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      cur_state <= nxt_state;
      pend_sel  <= nxt_pend;
      if (!pc_we && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (if_id_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a driver pushes model predictions,
// a negedge monitor pops and compares against the DUT outputs.
module tb_pipeline_ctrl;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       ex_br_sel = '0;
  logic             ex_mem_read = 1'b0;
  logic [4:0]       ex_rd = '0, id_rs1 = '0, id_rs2 = '0;
  logic             id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic             im_ready = 1'b1, dm_req = 1'b0, dm_ready = 1'b1;
  logic             pc_we, if_id_we, id_ex_we, ex_mem_we;
  logic             if_id_flush, id_ex_flush, mem_wb_flush;
  logic [1:0]       pc_sel;
  logic             state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ex_br_sel(ex_br_sel), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .im_ready(im_ready), .dm_req(dm_req), .dm_ready(dm_ready),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
    .pc_sel(pc_sel), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // ctl = {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, mem_wb_flush, pc_sel, state}
  typedef struct packed {
    logic [9:0] ctl;
    int         sc;
    int         fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0, n_fail = 0;

  // Reference model: waiting flag, remembered redirect target, plain-integer counters.
  bit       m_wait = 0;
  bit [1:0] m_pend = 0;
  int       m_sc = 0, m_fc = 0;

  task automatic drive(input bit r, input bit [1:0] br, input bit mr, input bit [4:0] rd,
                       input bit [4:0] s1, input bit [4:0] s2, input bit u1, input bit u2,
                       input bit imr, input bit dq, input bit dr);
    bit       pw, iw, ew, mw, ifl, efl, wfl;
    bit [1:0] sel;
    bit       hz;
    exp_t     e;
    @(posedge clk); #1;
    rst = r; ex_br_sel = br; ex_mem_read = mr; ex_rd = rd; id_rs1 = s1; id_rs2 = s2;
    id_rs1_used = u1; id_rs2_used = u2; im_ready = imr; dm_req = dq; dm_ready = dr;
    hz = mr && rd != 0 && ((u1 && s1 == rd) || (u2 && s2 == rd));
    {pw, iw, ew, mw, ifl, efl, wfl, sel} = {4'b1111, 3'b000, 2'b00};
    if (r) begin
      {pw, iw, ew, mw, ifl, efl, wfl} = 7'b0000111;
      m_wait = 0; m_pend = 0; m_sc = 0; m_fc = 0;
    end else if (dq && !dr) begin
      {pw, iw, ew, mw, wfl} = 5'b00001;
    end else if (m_wait) begin
      ifl = 1; efl = 1; pw = imr; sel = imr ? m_pend : 2'b00;
    end else if (br != 0) begin
      ifl = 1; efl = 1;
      if (imr) sel = br; else pw = 0;
    end else if (hz) begin
      pw = 0; iw = 0; efl = 1;
    end else if (!imr) begin
      pw = 0; ifl = 1;
    end
    e.ctl = {pw, iw, ew, mw, ifl, efl, wfl, sel, m_wait};
    e.sc = m_sc; e.fc = m_fc;
    exp_q.push_back(e);
    if (!r) begin
      if (!(dq && !dr)) begin
        if (m_wait && imr) m_wait = 0;
        else if (!m_wait && br != 0 && !imr) begin m_wait = 1; m_pend = br; end
      end
      if (!pw && m_sc < CMAX) m_sc++;
      if (ifl && m_fc < CMAX) m_fc++;
    end
  endtask

  task automatic idle(input bit imr);
    drive(0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, 0, imr, 0, 1);
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle against the oldest prediction.
  initial begin
    exp_t e;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        act = {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush,
               mem_wb_flush, pc_sel, state};
        n_tests++;
        if (act !== e.ctl) begin
          n_fail++;
          $display("FAIL ctl t=%0t got %b want %b", $time, act, e.ctl);
        end
        n_tests++;
        if (stall_cnt !== CNT_W'(e.sc)) begin
          n_fail++;
          $display("FAIL stall_cnt t=%0t got %0d want %0d", $time, stall_cnt, e.sc);
        end
        n_tests++;
        if (flush_cnt !== CNT_W'(e.fc)) begin
          n_fail++;
          $display("FAIL flush_cnt t=%0t got %0d want %0d", $time, flush_cnt, e.fc);
        end
      end
    end
  end

  initial begin
    // reset
    repeat (2) drive(1, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1);
    idle(1);
    // taken redirect with fetch ready
    drive(0, 2'b01, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1);
    // redirect with fetch not ready: 3 cycles waiting then ready
    drive(0, 2'b10, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    drive(0, 2'b11, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    idle(0);
    idle(1);
    idle(1);
    // load-use on rs2, then the same with rd=0
    drive(0, 2'b00, 1, 5'd5, 5'd1, 5'd5, 0, 1, 1, 0, 1);
    drive(0, 2'b00, 1, 5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 1);
    // data stall masking a redirect, then redirect taken
    drive(0, 2'b01, 1, 5'd3, 5'd3, 5'd0, 1, 0, 1, 1, 0);
    drive(0, 2'b01, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 1);
    // counter saturation
    repeat (20) idle(0);
    // reset pulse while waiting on a redirect
    drive(0, 2'b10, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    idle(0);
    drive(1, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    idle(1);
    idle(1);
    // random traffic with periodic resets
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0,
            ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 5)),
            5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            1'($urandom_range(0, 1)));
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-002 SHALL have port clk  in  1  rising-edge clock, sole clock.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ex_br_sel  in  2  branch select resolved in EX; 00 = sequential, 01/10/11 = redirect kind.
REQ-005 SHALL have port ex_mem_read  in  1  EX instruction is a load.
REQ-006 SHALL have port ex_rd  in  5  EX destination register.
REQ-007 SHALL have ports id_rs1, id_rs2  in  5 each  ID source registers.
REQ-008 SHALL have ports id_rs1_used, id_rs2_used  in  1 each  source valid flags.
REQ-009 SHALL have port im_ready  in  1  instruction fetch data valid this cycle.
REQ-010 SHALL have ports dm_req  in  1 and dm_ready  in  1  MEM-stage data access and completion.
REQ-011 SHALL have outputs pc_we, if_id_we, id_ex_we, ex_mem_we  out  1 each  stage write enables.
REQ-012 SHALL have outputs if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  bubble insertion; flush overrides the same register's write enable.
REQ-013 SHALL have output pc_sel  out  2  PC mux select.
REQ-014 SHALL have output state  out  1  0 = RUN, 1 = REDIR_WAIT.
REQ-015 SHALL have outputs stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters.

Function
REQ-016 Terms: dstall = dm_req & ~dm_ready; redir = ex_br_sel != 00; luse = ex_mem_read & ex_rd != 0 & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd)).
REQ-017 Default when no condition applies: all write enables 1, all flushes 0, pc_sel 00.
REQ-018 Priority, highest first: dstall, pending redirect/redir, luse, ~im_ready.
REQ-019 dstall, any state: all four write enables 0, mem_wb_flush 1; redir and luse ignored this cycle; state and pending select held.
REQ-020 RUN, redir, im_ready=1: pc_we 1, pc_sel = ex_br_sel, if_id_flush 1, id_ex_flush 1; stay RUN.
REQ-021 RUN, redir, im_ready=0: pc_we 0, if_id_flush 1, id_ex_flush 1; latch ex_br_sel into pend_sel; next state REDIR_WAIT.
REQ-022 REDIR_WAIT, no dstall: if_id_flush 1, id_ex_flush 1, ex_mem_we 1; pc_we = im_ready; pc_sel = pend_sel when im_ready, else 00; im_ready=1 -> RUN next cycle.
REQ-023 A new redir arriving in REDIR_WAIT SHALL be ignored (EX holds a bubble by construction).
REQ-024 luse in RUN: pc_we 0, if_id_we 0, id_ex_flush 1, others 1.
REQ-025 ~im_ready in RUN, no higher condition: pc_we 0, if_id_flush 1, id_ex_we and ex_mem_we 1.
REQ-026 Outputs combinational from state, pend_sel and inputs; state, pend_sel and counters registered; zero latency from inputs to controls.
REQ-027 stall_cnt SHALL increment each cycle pc_we=0 while rst low; flush_cnt SHALL increment each cycle if_id_flush=1; both saturate at all-ones, no wrap.

Reset
REQ-028 While rst high: state RUN, pend_sel 00, counters 0; outputs forced to pc_we 0, all write enables 0, all flushes 1, pc_sel 00.
REQ-029 Reset asserted mid REDIR_WAIT SHALL discard the pending redirect; first cycle after release behaves as RUN.

Verification
REQ-030 RUN, ex_br_sel=01, im_ready=1 -> same cycle pc_we=1, pc_sel=01, if_id_flush=1, id_ex_flush=1, flush_cnt +1.
REQ-031 ex_br_sel=10, im_ready=0 for 3 cycles then 1 -> state=1 for 3 cycles, pc_we=0, pc_sel=00; 4th cycle pc_we=1, pc_sel=10; next cycle state=0; stall_cnt +3.
REQ-032 ex_mem_read=1, ex_rd=5, id_rs2=5, id_rs2_used=1 -> pc_we=0, if_id_we=0, id_ex_flush=1; repeat with ex_rd=0 -> no stall.
REQ-033 dm_req=1, dm_ready=0 with ex_br_sel=01 simultaneous -> all write enables 0, mem_wb_flush=1, pc_sel=00; dm_ready=1 next cycle -> redirect taken.
REQ-034 Force stall_cnt path for 2^CNT_W+2 stalled cycles (CNT_W=4) -> stall_cnt holds 15.
REQ-035 rst pulse during REDIR_WAIT -> state=0, counters 0, pending select lost after release.
